// File: rtl/fmisc_issue_arbiter.sv
// fmisc_issue_arbiter: shares one FMisc datapath among NUM_REQ issuers, with FP/int writeback slots and a wakeup pulse.
// Define FMISC_ARB_OLDEST_FIRST_EN to grant by oldest ROB index instead of round-robin.
module fmisc_issue_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int XLEN    = 32,
    parameter int ROB_W   = 6,
    parameter int PREG_W  = 6,
    parameter int FLTOP_W = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [2:0]                 frm,
    input  logic                       redirect,
    input  logic [ROB_W-1:0]           redirect_idx,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*XLEN-1:0]    req_rs1,
    input  logic [NUM_REQ*XLEN-1:0]    req_rs2,
    input  logic [NUM_REQ*FLTOP_W-1:0] req_fltop,
    input  logic [NUM_REQ*3-1:0]       req_rm,
    input  logic [NUM_REQ-1:0]         req_uext,
    input  logic [NUM_REQ-1:0]         req_flt_we,
    input  logic [NUM_REQ-1:0]         req_we,
    input  logic [NUM_REQ*ROB_W-1:0]   req_rob_idx,
    input  logic [NUM_REQ*PREG_W-1:0]  req_rd,
    output logic [XLEN-1:0]            dp_rs1,
    output logic [XLEN-1:0]            dp_rs2,
    output logic [FLTOP_W-1:0]         dp_fltop,
    output logic [2:0]                 dp_rm,
    output logic                       dp_uext,
    input  logic [XLEN-1:0]            dp_res,
    input  logic [4:0]                 dp_fflags,
    output logic                       fwb_valid,
    input  logic                       fwb_ready,
    output logic [ROB_W-1:0]           fwb_rob_idx,
    output logic [PREG_W-1:0]          fwb_rd,
    output logic [XLEN-1:0]            fwb_res,
    output logic [4:0]                 fwb_fflags,
    output logic                       iwb_valid,
    input  logic                       iwb_ready,
    output logic                       iwb_we,
    output logic [ROB_W-1:0]           iwb_rob_idx,
    output logic [PREG_W-1:0]          iwb_rd,
    output logic [XLEN-1:0]            iwb_res,
    output logic [4:0]                 iwb_fflags,
    output logic                       wk_valid,
    output logic                       wk_flt,
    output logic                       wk_we,
    output logic [PREG_W-1:0]          wk_rd
);
    localparam int PTR_W = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;

    function automatic logic younger(input logic [ROB_W-1:0] x, input logic [ROB_W-1:0] r);
        return (x[ROB_W-1] == r[ROB_W-1]) ? (x[ROB_W-2:0] > r[ROB_W-2:0]) : (x[ROB_W-2:0] < r[ROB_W-2:0]);
    endfunction

    logic               fwb_valid_q, fwb_valid_d, iwb_valid_q, iwb_valid_d, iwb_we_q, iwb_we_d;
    logic [ROB_W-1:0]   fwb_rob_idx_q, fwb_rob_idx_d, iwb_rob_idx_q, iwb_rob_idx_d, wk_rob_idx_q, wk_rob_idx_d;
    logic [PREG_W-1:0]  fwb_rd_q, fwb_rd_d, iwb_rd_q, iwb_rd_d, wk_rd_q, wk_rd_d;
    logic [XLEN-1:0]    fwb_res_q, fwb_res_d, iwb_res_q, iwb_res_d;
    logic [4:0]         fwb_fflags_q, fwb_fflags_d, iwb_fflags_q, iwb_fflags_d;
    logic               wk_valid_q, wk_valid_d, wk_flt_q, wk_flt_d, wk_we_q, wk_we_d;
    logic               kill_f, kill_i, free_f, free_i;
    logic [NUM_REQ-1:0] elig;
    logic               gnt_any;
    logic [PTR_W-1:0]   gnt_idx;
    logic [2:0]         rm_sel;
    logic               flt_sel, we_sel;
    logic [ROB_W-1:0]   rob_sel;
    logic [PREG_W-1:0]  rd_sel;

    // A slot is free if empty, draining now, or being flushed by this cycle's redirect
    always_comb begin
        kill_f = redirect & younger(fwb_rob_idx_q, redirect_idx);
        kill_i = redirect & younger(iwb_rob_idx_q, redirect_idx);
        free_f = ~fwb_valid_q | fwb_ready | kill_f;
        free_i = ~iwb_valid_q | iwb_ready | kill_i;
        for (int i = 0; i < NUM_REQ; i++)
            elig[i] = rst & req_valid[i] & (req_flt_we[i] ? free_f : free_i)
                    & ~(redirect & younger(req_rob_idx[i*ROB_W +: ROB_W], redirect_idx));
    end

`ifdef FMISC_ARB_OLDEST_FIRST_EN
    logic [ROB_W-1:0] best_rob;

    // Pick the oldest eligible request; strict compare keeps ties on the lowest index
    always_comb begin
        gnt_any  = 1'b0;
        gnt_idx  = '0;
        best_rob = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (elig[i] && (!gnt_any || younger(best_rob, req_rob_idx[i*ROB_W +: ROB_W]))) begin
                gnt_any  = 1'b1;
                gnt_idx  = PTR_W'(i);
                best_rob = req_rob_idx[i*ROB_W +: ROB_W];
            end
    end
`else
    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;

    // Round-robin search starting at the pointer
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < NUM_REQ; k++)
            if (!gnt_any && elig[(int'(rr_ptr_q) + k) % NUM_REQ]) begin
                gnt_any = 1'b1;
                gnt_idx = PTR_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            end
        rr_ptr_d = gnt_any ? PTR_W'((int'(gnt_idx) + 1) % NUM_REQ) : rr_ptr_q;
    end

    // Pointer advances past the winner
    always_ff @(posedge clk) begin
        if (!rst) rr_ptr_q <= '0;
        else      rr_ptr_q <= rr_ptr_d;
    end
`endif

    // Drive the datapath and the one-hot ready from the granted request (req 0 when idle)
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++)
            req_ready[i] = gnt_any && (gnt_idx == PTR_W'(i));
        dp_rs1   = req_rs1[int'(gnt_idx)*XLEN +: XLEN];
        dp_rs2   = req_rs2[int'(gnt_idx)*XLEN +: XLEN];
        dp_fltop = req_fltop[int'(gnt_idx)*FLTOP_W +: FLTOP_W];
        rm_sel   = req_rm[int'(gnt_idx)*3 +: 3];
        dp_rm    = (rm_sel == 3'b111) ? frm : rm_sel;
        dp_uext  = req_uext[gnt_idx];
        flt_sel  = req_flt_we[gnt_idx];
        we_sel   = req_we[gnt_idx];
        rob_sel  = req_rob_idx[int'(gnt_idx)*ROB_W +: ROB_W];
        rd_sel   = req_rd[int'(gnt_idx)*PREG_W +: PREG_W];
    end

    // Slot capture has priority; otherwise drain or flush, else hold
    always_comb begin
        fwb_valid_d  = (gnt_any & flt_sel) | (fwb_valid_q & ~fwb_ready & ~kill_f);
        fwb_rob_idx_d = (gnt_any & flt_sel) ? rob_sel : fwb_rob_idx_q;
        fwb_rd_d     = (gnt_any & flt_sel) ? rd_sel : fwb_rd_q;
        fwb_res_d    = (gnt_any & flt_sel) ? dp_res : fwb_res_q;
        fwb_fflags_d = (gnt_any & flt_sel) ? dp_fflags : fwb_fflags_q;
        iwb_valid_d  = (gnt_any & ~flt_sel) | (iwb_valid_q & ~iwb_ready & ~kill_i);
        iwb_we_d     = (gnt_any & ~flt_sel) ? we_sel : iwb_we_q;
        iwb_rob_idx_d = (gnt_any & ~flt_sel) ? rob_sel : iwb_rob_idx_q;
        iwb_rd_d     = (gnt_any & ~flt_sel) ? rd_sel : iwb_rd_q;
        iwb_res_d    = (gnt_any & ~flt_sel) ? dp_res : iwb_res_q;
        iwb_fflags_d = (gnt_any & ~flt_sel) ? dp_fflags : iwb_fflags_q;
        wk_valid_d   = gnt_any;
        wk_flt_d     = gnt_any ? flt_sel : wk_flt_q;
        wk_we_d      = gnt_any ? (flt_sel | we_sel) : wk_we_q;
        wk_rd_d      = gnt_any ? rd_sel : wk_rd_q;
        wk_rob_idx_d = gnt_any ? rob_sel : wk_rob_idx_q;
    end

    // Slot and wakeup registers; reset drops any in-flight op
    always_ff @(posedge clk) begin
        if (!rst) begin
            fwb_valid_q   <= 1'b0;
            fwb_rob_idx_q <= '0;
            fwb_rd_q      <= '0;
            fwb_res_q     <= '0;
            fwb_fflags_q  <= '0;
            iwb_valid_q   <= 1'b0;
            iwb_we_q      <= 1'b0;
            iwb_rob_idx_q <= '0;
            iwb_rd_q      <= '0;
            iwb_res_q     <= '0;
            iwb_fflags_q  <= '0;
            wk_valid_q    <= 1'b0;
            wk_flt_q      <= 1'b0;
            wk_we_q       <= 1'b0;
            wk_rd_q       <= '0;
            wk_rob_idx_q  <= '0;
        end else begin
            fwb_valid_q   <= fwb_valid_d;
            fwb_rob_idx_q <= fwb_rob_idx_d;
            fwb_rd_q      <= fwb_rd_d;
            fwb_res_q     <= fwb_res_d;
            fwb_fflags_q  <= fwb_fflags_d;
            iwb_valid_q   <= iwb_valid_d;
            iwb_we_q      <= iwb_we_d;
            iwb_rob_idx_q <= iwb_rob_idx_d;
            iwb_rd_q      <= iwb_rd_d;
            iwb_res_q     <= iwb_res_d;
            iwb_fflags_q  <= iwb_fflags_d;
            wk_valid_q    <= wk_valid_d;
            wk_flt_q      <= wk_flt_d;
            wk_we_q       <= wk_we_d;
            wk_rd_q       <= wk_rd_d;
            wk_rob_idx_q  <= wk_rob_idx_d;
        end
    end

    assign fwb_valid   = fwb_valid_q;
    assign fwb_rob_idx = fwb_rob_idx_q;
    assign fwb_rd      = fwb_rd_q;
    assign fwb_res     = fwb_res_q;
    assign fwb_fflags  = fwb_fflags_q;
    assign iwb_valid   = iwb_valid_q;
    assign iwb_we      = iwb_we_q;
    assign iwb_rob_idx = iwb_rob_idx_q;
    assign iwb_rd      = iwb_rd_q;
    assign iwb_res     = iwb_res_q;
    assign iwb_fflags  = iwb_fflags_q;
    assign wk_valid    = wk_valid_q & ~(redirect & younger(wk_rob_idx_q, redirect_idx));
    assign wk_flt      = wk_flt_q;
    assign wk_we       = wk_we_q;
    assign wk_rd       = wk_rd_q;
endmodule

// File: tb/tb_fmisc_issue_arbiter.sv
// tb_fmisc_issue_arbiter: directed scenarios plus randomized traffic against a slot-level reference model.
module tb_fmisc_issue_arbiter;
    localparam int N = 2, XL = 32, RW = 6, PW = 6, FW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, redirect, fwb_ready, iwb_ready;
    logic [2:0] frm;
    logic [RW-1:0] redirect_idx;
    logic [N-1:0] req_valid, req_ready, req_uext, req_flt_we, req_we;
    logic [N*XL-1:0] req_rs1, req_rs2;
    logic [N*FW-1:0] req_fltop;
    logic [N*3-1:0] req_rm;
    logic [N*RW-1:0] req_rob_idx;
    logic [N*PW-1:0] req_rd;
    logic [XL-1:0] dp_rs1, dp_rs2, dp_res, fwb_res, iwb_res;
    logic [FW-1:0] dp_fltop;
    logic [2:0] dp_rm;
    logic dp_uext, fwb_valid, iwb_valid, iwb_we, wk_valid, wk_flt, wk_we;
    logic [4:0] dp_fflags, fwb_fflags, iwb_fflags;
    logic [RW-1:0] fwb_rob_idx, iwb_rob_idx;
    logic [PW-1:0] fwb_rd, iwb_rd, wk_rd;

    function automatic logic [XL-1:0] dpf_res(input logic [XL-1:0] a, input logic [XL-1:0] b,
                                              input logic [FW-1:0] op, input logic [2:0] rm, input logic ux);
        return a + {b[XL-2:0], 1'b0} + XL'({op, rm, ux});
    endfunction
    function automatic logic [4:0] dpf_ff(input logic [XL-1:0] a, input logic [XL-1:0] b,
                                         input logic [2:0] rm, input logic ux);
        return a[4:0] ^ b[9:5] ^ {rm, ux, 1'b1};
    endfunction
    assign dp_res    = dpf_res(dp_rs1, dp_rs2, dp_fltop, dp_rm, dp_uext);
    assign dp_fflags = dpf_ff(dp_rs1, dp_rs2, dp_rm, dp_uext);

    fmisc_issue_arbiter #(.NUM_REQ(N), .XLEN(XL), .ROB_W(RW), .PREG_W(PW), .FLTOP_W(FW)) dut (
        .clk(clk), .rst(rst), .frm(frm), .redirect(redirect), .redirect_idx(redirect_idx),
        .req_valid(req_valid), .req_ready(req_ready), .req_rs1(req_rs1), .req_rs2(req_rs2),
        .req_fltop(req_fltop), .req_rm(req_rm), .req_uext(req_uext), .req_flt_we(req_flt_we),
        .req_we(req_we), .req_rob_idx(req_rob_idx), .req_rd(req_rd),
        .dp_rs1(dp_rs1), .dp_rs2(dp_rs2), .dp_fltop(dp_fltop), .dp_rm(dp_rm), .dp_uext(dp_uext),
        .dp_res(dp_res), .dp_fflags(dp_fflags),
        .fwb_valid(fwb_valid), .fwb_ready(fwb_ready), .fwb_rob_idx(fwb_rob_idx), .fwb_rd(fwb_rd),
        .fwb_res(fwb_res), .fwb_fflags(fwb_fflags),
        .iwb_valid(iwb_valid), .iwb_ready(iwb_ready), .iwb_we(iwb_we), .iwb_rob_idx(iwb_rob_idx),
        .iwb_rd(iwb_rd), .iwb_res(iwb_res), .iwb_fflags(iwb_fflags),
        .wk_valid(wk_valid), .wk_flt(wk_flt), .wk_we(wk_we), .wk_rd(wk_rd)
    );

    typedef struct packed {
        logic          v;
        logic [RW-1:0] rob;
        logic [PW-1:0] rd;
        logic [XL-1:0] res;
        logic [4:0]    ff;
        logic          we;
    } slot_t;

    slot_t ms_f, ms_i, ms_wk;
    int mptr;
    int n_vec = 0, n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ROB age as modular distance: x is younger than r when 0 < x-r < half the ring
    function automatic bit m_younger(input logic [RW-1:0] x, input logic [RW-1:0] r);
        int d;
        d = (int'(x) - int'(r)) & ((1 << RW) - 1);
        return d > 0 && d < (1 << (RW - 1));
    endfunction

    function automatic logic [RW-1:0] rob_of(input int i);
        return req_rob_idx[i*RW +: RW];
    endfunction

    // One clock: check all outputs against the model, advance the model, then clock the DUT
    task automatic step();
        int g, s;
        bit free_f, free_i, exp_wk, flt;
        bit el[N];
        logic [2:0] erm;
        logic [XL-1:0] r;
        logic [4:0] f;
        #1;
        check("fwb_valid", fwb_valid, ms_f.v);
        if (ms_f.v) begin
            check("fwb_rob", fwb_rob_idx, ms_f.rob);
            check("fwb_rd", fwb_rd, ms_f.rd);
            check("fwb_res", fwb_res, ms_f.res);
            check("fwb_ff", fwb_fflags, ms_f.ff);
        end
        check("iwb_valid", iwb_valid, ms_i.v);
        if (ms_i.v) begin
            check("iwb_we", iwb_we, ms_i.we);
            check("iwb_rob", iwb_rob_idx, ms_i.rob);
            check("iwb_rd", iwb_rd, ms_i.rd);
            check("iwb_res", iwb_res, ms_i.res);
            check("iwb_ff", iwb_fflags, ms_i.ff);
        end
        exp_wk = ms_wk.v && !(redirect && m_younger(ms_wk.rob, redirect_idx));
        check("wk_valid", wk_valid, exp_wk);
        if (exp_wk) begin
            check("wk_flt", wk_flt, ms_wk.ff[0]);
            check("wk_we", wk_we, ms_wk.we);
            check("wk_rd", wk_rd, ms_wk.rd);
        end
        g = -1;
        if (rst) begin
            free_f = !ms_f.v || fwb_ready || (redirect && m_younger(ms_f.rob, redirect_idx));
            free_i = !ms_i.v || iwb_ready || (redirect && m_younger(ms_i.rob, redirect_idx));
            for (int i = 0; i < N; i++)
                el[i] = req_valid[i] && (req_flt_we[i] ? free_f : free_i)
                        && !(redirect && m_younger(rob_of(i), redirect_idx));
`ifdef FMISC_ARB_OLDEST_FIRST_EN
            for (int i = 0; i < N; i++)
                if (el[i] && (g < 0 || m_younger(rob_of(g), rob_of(i)))) g = i;
`else
            for (int k = 0; k < N; k++)
                if (g < 0 && el[(mptr + k) % N]) g = (mptr + k) % N;
`endif
        end
        check("req_ready", req_ready, g >= 0 ? N'(1) << g : '0);
        s = g < 0 ? 0 : g;
        erm = (req_rm[s*3 +: 3] == 3'b111) ? frm : req_rm[s*3 +: 3];
        check("dp_rs1", dp_rs1, req_rs1[s*XL +: XL]);
        check("dp_rs2", dp_rs2, req_rs2[s*XL +: XL]);
        check("dp_fltop", dp_fltop, req_fltop[s*FW +: FW]);
        check("dp_rm", dp_rm, erm);
        check("dp_uext", dp_uext, req_uext[s]);
        if (!rst) begin
            ms_f = '0; ms_i = '0; ms_wk = '0; mptr = 0;
        end else begin
            if (ms_f.v && (fwb_ready || (redirect && m_younger(ms_f.rob, redirect_idx)))) ms_f.v = 1'b0;
            if (ms_i.v && (iwb_ready || (redirect && m_younger(ms_i.rob, redirect_idx)))) ms_i.v = 1'b0;
            ms_wk.v = g >= 0;
            if (g >= 0) begin
                flt = req_flt_we[g];
                r = dpf_res(req_rs1[g*XL +: XL], req_rs2[g*XL +: XL], req_fltop[g*FW +: FW], erm, req_uext[g]);
                f = dpf_ff(req_rs1[g*XL +: XL], req_rs2[g*XL +: XL], erm, req_uext[g]);
                if (flt) ms_f = '{1'b1, rob_of(g), req_rd[g*PW +: PW], r, f, 1'b1};
                else     ms_i = '{1'b1, rob_of(g), req_rd[g*PW +: PW], r, f, req_we[g]};
                ms_wk = '{1'b1, rob_of(g), req_rd[g*PW +: PW], '0, {4'b0, flt}, flt | req_we[g]};
                mptr = (g + 1) % N;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input bit v, input bit flt, input logic [RW-1:0] rob, input logic [2:0] rm);
        req_valid[i] = v;
        req_flt_we[i] = flt;
        req_rob_idx[i*RW +: RW] = rob;
        req_rm[i*3 +: 3] = rm;
    endtask

    task automatic randomize_inputs();
        rst = ($urandom % 60) != 0;
        frm = 3'($urandom);
        redirect = ($urandom % 5) == 0;
        redirect_idx = RW'($urandom);
        fwb_ready = 1'($urandom);
        iwb_ready = 1'($urandom);
        for (int i = 0; i < N; i++) begin
            req_valid[i] = ($urandom % 4) != 0;
            req_flt_we[i] = 1'($urandom);
            req_we[i] = 1'($urandom);
            req_uext[i] = 1'($urandom);
            req_rs1[i*XL +: XL] = $urandom;
            req_rs2[i*XL +: XL] = $urandom;
            req_fltop[i*FW +: FW] = FW'($urandom);
            req_rm[i*3 +: 3] = ($urandom % 3 == 0) ? 3'b111 : 3'($urandom);
            req_rob_idx[i*RW +: RW] = RW'($urandom);
            req_rd[i*PW +: PW] = PW'($urandom);
        end
    endtask

    initial begin
        randomize_inputs();
        rst = 1'b0; redirect = 1'b0; req_valid = '0; fwb_ready = 1'b1; iwb_ready = 1'b1;
        ms_f = '0; ms_i = '0; ms_wk = '0; mptr = 0;
        @(posedge clk);
        #1;
        // reset held with both requesters asking
        req_valid = 2'b11;
        step();
        step();
        rst = 1'b1;
        req_valid = '0;
        #1;
        check("t1_fwb_valid", fwb_valid, 1'b0);
        check("t1_iwb_valid", iwb_valid, 1'b0);
        check("t1_wk_valid", wk_valid, 1'b0);
        // both FP requesters: round-robin alternates 0,1,0,1
        set_req(0, 1, 1, 6'd1, 3'b000);
        set_req(1, 1, 1, 6'd2, 3'b000);
        for (int k = 0; k < 4; k++) begin
            step();
            check("t2_fwb_valid", fwb_valid, 1'b1);
            check("t2_wk_valid", wk_valid, 1'b1);
`ifndef FMISC_ARB_OLDEST_FIRST_EN
            check("t2_order", fwb_rob_idx, (k % 2 == 0) ? 6'd1 : 6'd2);
`endif
        end
        // FP slot stalled: int request gets through, FP request waits for fwb_ready
        req_valid = '0;
        step();
        fwb_ready = 1'b0;
        set_req(0, 1, 1, 6'd10, 3'b000);
        set_req(1, 0, 0, 6'd11, 3'b000);
        step();
        check("t3_fwb_rob", fwb_rob_idx, 6'd10);
        set_req(0, 1, 1, 6'd12, 3'b000);
        set_req(1, 1, 0, 6'd11, 3'b000);
        step();
        check("t3_iwb_valid", iwb_valid, 1'b1);
        check("t3_iwb_rob", iwb_rob_idx, 6'd11);
        req_valid[1] = 1'b0;
        step();
        check("t3_fwb_hold", fwb_rob_idx, 6'd10);
        fwb_ready = 1'b1;
        step();
        check("t3_fwb_next", fwb_rob_idx, 6'd12);
        // redirect flushes a younger slot, keeps an older one across the wrap
        req_valid = '0;
        step();
        fwb_ready = 1'b0;
        set_req(0, 1, 1, 6'b0_00101, 3'b000);
        step();
        req_valid = '0; redirect = 1'b1; redirect_idx = 6'b0_00011;
        step();
        check("t4_flush", fwb_valid, 1'b0);
        redirect = 1'b0;
        set_req(0, 1, 1, 6'b0_11110, 3'b000);
        step();
        req_valid = '0; redirect = 1'b1; redirect_idx = 6'b1_00010;
        step();
        check("t4_keep", fwb_valid, 1'b1);
        redirect = 1'b0; fwb_ready = 1'b1;
        // dynamic rounding mode substitution
        frm = 3'b010;
        set_req(0, 1, 1, 6'd20, 3'b111);
        #1;
        check("t5_dyn_rm", dp_rm, 3'b010);
        step();
        set_req(0, 1, 1, 6'd21, 3'b001);
        #1;
        check("t5_static_rm", dp_rm, 3'b001);
        step();
`ifdef FMISC_ARB_OLDEST_FIRST_EN
        // oldest ROB index wins regardless of position
        set_req(0, 1, 1, 6'd9, 3'b000);
        set_req(1, 1, 1, 6'd4, 3'b000);
        step();
        check("t6_first", fwb_rob_idx, 6'd4);
        req_valid[1] = 1'b0;
        step();
        check("t6_second", fwb_rob_idx, 6'd9);
`endif
        for (int c = 0; c < 3000; c++) begin
            randomize_inputs();
            step();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
